// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Provides the NOP encoding, the sequential PC step and the default fetch-queue entry layout.
package if_pkg;

    localparam int IF_ADDR_W  = 32;
    localparam int IF_INSTR_W = 32;

    localparam int unsigned PC_STEP = 4;
    localparam logic [IF_INSTR_W-1:0] INSTR_NOP = '0;

    typedef struct packed {
        logic [IF_ADDR_W-1:0]  pc;
        logic [IF_INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries between the IF stage and ID.
// Clear beats push/pop; a push into a full queue is accepted only alongside a pop.
module fetch_queue
    import if_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fq_entry_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  T                           i_push_data,
    input  logic                       i_pop,
    output T                           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= nextPtr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= nextPtr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once the count covers them.
    always_ff @(posedge clk) begin
        if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, issues credit-limited fetches and hands queued words to ID.
// Optional macro IF_PERF_CNT_EN adds fetch and redirect event counters.
module instr_fetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_pc_plus_4
`ifdef IF_PERF_CNT_EN
   ,output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_redirect_cnt
`endif
);

    localparam int CNT_W = $clog2(FQ_DEPTH + 1);
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;

    entry_t            w_head;
    entry_t            w_push_data;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_used;
    logic              w_empty;
    logic              w_full;
    logic              w_credit;
    logic              w_push;
    logic              w_pop;

    // An issued fetch reserves a queue slot, so its response can always be enqueued.
    assign w_used   = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_credit = !w_full && (w_used < (CNT_W + 1)'(FQ_DEPTH));
    assign imem_req = !reset && !redirect_valid && w_credit;
    assign imem_addr = r_pc;

    assign w_push      = r_inflight && !redirect_valid;
    assign w_push_data = '{pc: r_inflight_pc, instr: imem_rdata};
    assign w_pop       = !w_empty && id_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + PC_INC;
            end
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .T     (entry_t)
    ) u_fetch_queue (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    assign id_valid     = !w_empty;
    assign id_instr     = w_empty ? INSTR_W'(INSTR_NOP) : w_head.instr;
    assign id_pc        = w_empty ? '0 : w_head.pc;
    assign id_pc_plus_4 = w_empty ? '0 : w_head.pc + PC_INC;

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (imem_req)       perf_fetch_cnt    <= perf_fetch_cnt + 32'd1;
            if (redirect_valid) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a queue-based reference model for the 32-bit build
// plus a cycle table for an 8-bit, 2-entry build that exercises PC wrap.
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus_4;

    logic        imem_req8;
    logic [7:0]  imem_addr8;
    logic [31:0] imem_rdata8 = '0;
    logic        id_valid8;
    logic        id_ready8 = 1'b1;
    logic [31:0] id_instr8;
    logic [7:0]  id_pc8;
    logic [7:0]  id_pc_plus_48;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_redirect_cnt;
    logic [31:0] perf_fetch_cnt8, perf_redirect_cnt8;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W(32), .INSTR_W(32), .FQ_DEPTH(DEPTH), .RESET_PC(32'h100)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus_4(id_pc_plus_4)
`ifdef IF_PERF_CNT_EN
       ,.perf_fetch_cnt(perf_fetch_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    instr_fetch_unit #(
        .ADDR_W(8), .INSTR_W(32), .FQ_DEPTH(2), .RESET_PC(8'hF8)
    ) dut8 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req8), .imem_addr(imem_addr8), .imem_rdata(imem_rdata8),
        .redirect_valid(1'b0), .redirect_pc(8'h00),
        .id_valid(id_valid8), .id_ready(id_ready8), .id_instr(id_instr8),
        .id_pc(id_pc8), .id_pc_plus_4(id_pc_plus_48)
`ifdef IF_PERF_CNT_EN
       ,.perf_fetch_cnt(perf_fetch_cnt8), .perf_redirect_cnt(perf_redirect_cnt8)
`endif
    );

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Instruction memories: one-cycle read latency, garbage when not requested.
    always @(posedge clk) begin
        imem_rdata  <= imem_req  ? instrOf(imem_addr) : 32'hBAD0_BAD0;
        imem_rdata8 <= imem_req8 ? instrOf({24'h0, imem_addr8}) : 32'hBAD1_BAD1;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } qent_t;

    qent_t       mq[$];
    logic [31:0] mPc;
    logic [31:0] mInflPc;
    bit          mInfl;
    int          expFetch;
    int          expRedir;

    typedef struct {
        bit         rdy;
        bit         req;
        logic [7:0] addr;
        bit         valid;
        logic [7:0] pc;
        logic [7:0] pc4;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mPc = 32'h100;
        mInfl = 1'b0;
        mInflPc = 32'h0;
        expFetch = 0;
        expRedir = 0;
    endtask

    task automatic checkReset();
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst_imem_addr", imem_addr, 32'h100);
        checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
        checkOutput("rst_id_instr", id_instr, 32'd0);
        checkOutput("rst_id_pc", id_pc, 32'd0);
        checkOutput("rst_id_pc_plus_4", id_pc_plus_4, 32'd0);
        checkOutput("rst8_imem_addr", 32'(imem_addr8), 32'hF8);
        checkOutput("rst8_id_valid", 32'(id_valid8), 32'd0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkReset();
        reset = 1'b0;
        modelReset();
    endtask

    // One cycle against the model; called at posedge+1, returns at the next posedge+1.
    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
        bit          expReq;
        bit          expValid;
        qent_t       h;
        redirect_valid = rv;
        redirect_pc = rpc;
        id_ready = rdy;
        @(negedge clk);
        expReq = !rv && ((mq.size() + int'(mInfl)) < DEPTH);
        expValid = (mq.size() > 0);
        if (expValid) h = mq[0];
        else h = '{pc: 32'h0, instr: 32'h0};
        checkOutput("imem_req", 32'(imem_req), 32'(expReq));
        checkOutput("imem_addr", imem_addr, mPc);
        checkOutput("id_valid", 32'(id_valid), 32'(expValid));
        checkOutput("id_pc", id_pc, h.pc);
        checkOutput("id_instr", id_instr, h.instr);
        checkOutput("id_pc_plus_4", id_pc_plus_4, expValid ? h.pc + 32'd4 : 32'd0);
        if (expReq) expFetch++;
        if (rv) expRedir++;
        if (rv) begin
            mq.delete();
            mInfl = 1'b0;
            mPc = rpc;
        end else begin
            if (expValid && rdy) void'(mq.pop_front());
            if (mInfl) mq.push_back('{pc: mInflPc, instr: instrOf(mInflPc)});
            if (expReq) begin
                mInfl = 1'b1;
                mInflPc = mPc;
                mPc = mPc + 32'd4;
            end else begin
                mInfl = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkPerf(input string tag);
`ifdef IF_PERF_CNT_EN
        checkOutput({tag, "_perf_fetch"}, perf_fetch_cnt, 32'(expFetch));
        checkOutput({tag, "_perf_redirect"}, perf_redirect_cnt, 32'(expRedir));
`else
        if (tag.len() < 0) $display("[TB] %s", tag);
`endif
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] rpc;
        bit          rv;

        // 8-bit build, 2 entries, id_ready held high: fetch wraps 0xFC -> 0x00.
        vecs[0] = '{1'b1, 1'b1, 8'hF8, 1'b0, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 8'hFC, 1'b0, 8'h00, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hF8, 8'hFC};
        vecs[3] = '{1'b1, 1'b1, 8'h00, 1'b1, 8'hFC, 8'h00};
        vecs[4] = '{1'b1, 1'b1, 8'h04, 1'b0, 8'h00, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 8'h08, 1'b1, 8'h00, 8'h04};
        vecs[6] = '{1'b1, 1'b1, 8'h08, 1'b1, 8'h04, 8'h08};
        vecs[7] = '{1'b1, 1'b1, 8'h0C, 1'b0, 8'h00, 8'h00};
        vecs[8] = '{1'b1, 1'b0, 8'h10, 1'b1, 8'h08, 8'h0C};

        doReset();
        for (int i = 0; i < 9; i++) begin
            id_ready8 = vecs[i].rdy;
            @(negedge clk);
            checkOutput($sformatf("w8_req_%0d", i), 32'(imem_req8), 32'(vecs[i].req));
            checkOutput($sformatf("w8_addr_%0d", i), 32'(imem_addr8), 32'(vecs[i].addr));
            checkOutput($sformatf("w8_valid_%0d", i), 32'(id_valid8), 32'(vecs[i].valid));
            checkOutput($sformatf("w8_pc_%0d", i), 32'(id_pc8), 32'(vecs[i].pc));
            checkOutput($sformatf("w8_pc4_%0d", i), 32'(id_pc_plus_48), 32'(vecs[i].pc4));
            checkOutput($sformatf("w8_instr_%0d", i), id_instr8,
                        vecs[i].valid ? instrOf({24'h0, vecs[i].pc}) : 32'h0);
            @(posedge clk);
            #1;
        end

        // Streaming from RESET_PC with ID always ready.
        doReset();
        checkPerf("post_reset");
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0, 1'b1);

        // ID stalls until the queue fills, then drains.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1);

        // Redirect with three entries queued and one fetch in flight.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h40, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1);

        // Back-to-back redirects: the second target wins.
        applyStimulus(1'b1, 32'h40, 1'b1);
        applyStimulus(1'b1, 32'h80, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1);

        // Random ID back-pressure and redirects, including targets near the 32-bit wrap.
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            rv = ($urandom_range(0, 99) < 6);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : {r[31:2], 2'b00};
            applyStimulus(rv, rpc, ($urandom_range(0, 99) < 70));
        end
        checkPerf("random");

        // Asynchronous reset between clock edges.
        #3;
        reset = 1'b1;
        #1;
        checkReset();
        modelReset();
        checkPerf("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h200, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, $urandom_range(0, 1) == 1);
        checkPerf("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
